conv3x3_ctrl: RTL and testbench
===============================

Name: conv3x3_ctrl

Overview:
- Consumer-side controller for the 3x3 window memory.
- Drives `rd` to pull one 3x3 pixel window per cycle, computes a signed 3x3 convolution, and writes one 8-bit result per window back through `wr`/`pixelw`.
- Sequences one full frame per `start` pulse: rewinds the memory address counters, streams all windows, drains its pipeline, then signals `done`.

Parameters:
- IMG_W, 256, output pixels per row (window positions per row)
- IMG_H, 32, output rows per frame
- CW, 6, coefficient width (signed two's complement)
- SHIFT, 4, arithmetic right shift applied to the convolution sum

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a frame when idle
- coef  input  9*CW  kernel; k1 = coef[CW-1:0] … k9 = coef[9*CW-1:8*CW]; must be stable while busy
- pixelr1..pixelr9  input  8 each  window pixels from the memory, row-major (1 = top-left, 9 = bottom-right)
- mem_rst_n  output  1  synchronous rewind to the memory address counters, active low
- rd  output  1  window read request to the memory
- wr  output  1  result write strobe to the memory
- pixelw  output  8  result pixel
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset: async on rst_n low. State = IDLE. mem_rst_n=1, rd=0, wr=0, pixelw=0, busy=0, done=0; all counters and pipeline valids cleared. Reset mid-frame aborts at once; no further rd/wr.
- Registered outputs: all outputs are registered; no combinational path from input to output.
- N: N = IMG_W*IMG_H = 8192 at defaults; 14-bit read counter.
- FSM:
  - IDLE: start=1 → REWIND. start while not IDLE is ignored.
  - REWIND: exactly 1 cycle, mem_rst_n=0, rd=0 → RUN.
  - RUN: rd=1 on every cycle, read counter increments. After the Nth rd cycle → DRAIN (rd=0 from the next cycle).
  - DRAIN: wait until all pipeline valids are 0 → DONE.
  - DONE: done=1 for 1 cycle, busy=0 from the next cycle → IDLE.
  - busy=1 in REWIND, RUN, DRAIN and DONE.
- Memory timing: the memory returns the window registered. Pixels requested with rd in cycle t are valid in cycle t+1. Valid chain: v0 = rd delayed 1 cycle.
- Pipeline stage 1 (capture on v0):
  - prod_i = {0, pixelr_i} × k_i, signed, 8+CW bits (14 at defaults).
  - sum = Σprod_i, sign-extended to 8+CW+4 bits (18 at defaults), registered; v1 = v0 delayed.
- Pipeline stage 2 (capture on v1):
  - s = sum >>> SHIFT (arithmetic).
  - pixelw = 0 if s<0; 255 if s>255; otherwise s[7:0].
  - wr = v1 delayed (one-cycle strobe per result).
- Latency: rd cycle t → wr in cycle t+3. Exactly N wr pulses per frame, in window order. pixelw holds its last value when wr=0.
- done timing: done asserts the cycle after the last wr, i.e. t_last_rd + 4.
- Back-to-back frames: start accepted the cycle after done drops (IDLE). REWIND guarantees the memory counters restart at window 0.
- coef changes while busy are not supported; behaviour is undefined.

Test Plan:
- Identity: k5=16, others 0, SHIFT=4; memory ramp → each pixelw equals the pixelr5 of its window; 8192 wr pulses; rd high exactly 8192 consecutive cycles.
- Box sum: all k=1, uniform image value 90 → every pixelw = 810>>4 = 50.
- Saturation: k5=31 on pixel 255 → 7905>>4 = 494 → pixelw=255. k5=-16 on pixel 200 → -200 → pixelw=0.
- Timing: start at cycle 0 → mem_rst_n low at cycle 1; rd cycles 2..8193; first wr at cycle 5; last wr at cycle 8196; done at 8197; busy low at 8198.
- Robustness: start re-pulsed during RUN → ignored, wr count still 8192. rst_n low at read 100 → rd/wr/busy drop immediately; a fresh start after release completes a full frame with correct first pixel.
- Two frames back-to-back with different coef → second frame outputs match the second kernel from window 0.

Source files
------------

// File: rtl/conv3x3_ctrl.sv
// Frame sequencer and two-stage signed 3x3 convolution datapath
// sitting between the window memory read and result write ports.
module conv3x3_ctrl #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 32,
    parameter int CW    = 6,
    parameter int SHIFT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [9*CW-1:0] coef,
    input  logic [7:0]      pixelr1,
    input  logic [7:0]      pixelr2,
    input  logic [7:0]      pixelr3,
    input  logic [7:0]      pixelr4,
    input  logic [7:0]      pixelr5,
    input  logic [7:0]      pixelr6,
    input  logic [7:0]      pixelr7,
    input  logic [7:0]      pixelr8,
    input  logic [7:0]      pixelr9,
    output logic            mem_rst_n,
    output logic            rd,
    output logic            wr,
    output logic [7:0]      pixelw,
    output logic            busy,
    output logic            done
);

    localparam int N    = IMG_W * IMG_H;
    localparam int CNTW = $clog2(N + 1);
    localparam int SW   = 8 + CW + 4;
    localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);
    localparam logic signed [SW-1:0] MAXV = SW'(255);

    typedef enum logic [2:0] {
        IDLE,
        REWIND,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic rd_q, rd_d;
    logic mrst_q, mrst_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic v0_q, v1_q, wr_q;
    logic signed [SW-1:0] sum_q, sum_c, s_c;
    logic [7:0] pixw_q, pix_c;
    logic [7:0] px [9];

    assign px[0] = pixelr1;
    assign px[1] = pixelr2;
    assign px[2] = pixelr3;
    assign px[3] = pixelr4;
    assign px[4] = pixelr5;
    assign px[5] = pixelr6;
    assign px[6] = pixelr7;
    assign px[7] = pixelr8;
    assign px[8] = pixelr9;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = 1'b0;
        mrst_d  = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REWIND;
                    mrst_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            REWIND: begin
                state_d = RUN;
                rd_d    = 1'b1;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DRAIN;
                else rd_d = 1'b1;
            end
            DRAIN: begin
                // wr of the last window is already in flight from v1
                if (!rd_q && !v0_q && !v1_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic signed [SW-1:0] pe, ke;
        sum_c = '0;
        for (int i = 0; i < 9; i++) begin
            pe = {{(SW-8){1'b0}}, px[i]};
            ke = {{(SW-CW){coef[i*CW+CW-1]}}, coef[i*CW +: CW]};
            sum_c = sum_c + pe * ke;
        end
    end

    always_comb begin
        s_c = sum_q >>> SHIFT;
        if (s_c[SW-1]) pix_c = 8'd0;
        else if (s_c > MAXV) pix_c = 8'd255;
        else pix_c = s_c[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            mrst_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            wr_q    <= 1'b0;
            sum_q   <= '0;
            pixw_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            mrst_q  <= mrst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            v0_q    <= rd_q;
            v1_q    <= v0_q;
            wr_q    <= v1_q;
            if (v0_q) sum_q <= sum_c;
            if (v1_q) pixw_q <= pix_c;
        end
    end

    assign mem_rst_n = mrst_q;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign pixelw    = pixw_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv3x3_ctrl.sv
// Directed bench for conv3x3_ctrl with a behavioural window memory
// and a reference convolution for every written pixel.
module tb_conv3x3_ctrl;

    localparam int CW    = 6;
    localparam int SHIFT = 4;
    localparam int N     = 8192;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [9*CW-1:0] coef = '0;
    logic [7:0]      pr [1:9];
    logic            mem_rst_n, rd, wr, busy, done;
    logic [7:0]      pixelw;

    int checks = 0;
    int failures = 0;
    int kk [1:9];
    int mode = 0;
    int mul = 1;
    int uval = 0;

    conv3x3_ctrl #(.IMG_W(256), .IMG_H(32), .CW(CW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .coef(coef),
        .pixelr1(pr[1]), .pixelr2(pr[2]), .pixelr3(pr[3]),
        .pixelr4(pr[4]), .pixelr5(pr[5]), .pixelr6(pr[6]),
        .pixelr7(pr[7]), .pixelr8(pr[8]), .pixelr9(pr[9]),
        .mem_rst_n(mem_rst_n), .rd(rd), .wr(wr), .pixelw(pixelw),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int pix(int idx, int i);
        if (mode != 0) return uval;
        return (idx * mul + i * 37) & 255;
    endfunction

    function automatic int model(int idx);
        int s = 0;
        for (int i = 1; i <= 9; i++) s += pix(idx, i) * kk[i];
        s = s >>> SHIFT;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // registered window memory: rewinds on mem_rst_n, advances on rd
    int addr = 0;
    always @(posedge clk) begin
        if (!mem_rst_n) addr <= 0;
        else if (rd) begin
            for (int i = 1; i <= 9; i++) pr[i] <= 8'(pix(addr, i));
            addr <= addr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t0, rew_t, rd_n, rd_first, rd_last, wr_n, wr_first, wr_last;
    int done_t, bfall_t, perr, first_pix;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (start && !busy) begin
            t0 = cyc; rew_t = -1; rd_n = 0; rd_first = -1; rd_last = -1;
            wr_n = 0; wr_first = -1; wr_last = -1; done_t = -1;
            bfall_t = -1; perr = 0; first_pix = -1;
        end
        if (!mem_rst_n) rew_t = cyc - t0;
        if (rd) begin
            if (rd_n == 0) rd_first = cyc - t0;
            rd_last = cyc - t0;
            rd_n++;
        end
        if (wr) begin
            if (wr_n == 0) begin
                wr_first = cyc - t0;
                first_pix = int'(pixelw);
            end
            if (int'(pixelw) != model(wr_n)) perr++;
            wr_last = cyc - t0;
            wr_n++;
        end
        if (done) done_t = cyc - t0;
        if (busy_prev && !busy) bfall_t = cyc - t0;
        busy_prev = busy;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_k(input int c5, input int others);
        for (int i = 1; i <= 9; i++) begin
            kk[i] = (i == 5) ? c5 : others;
            coef[(i-1)*CW +: CW] = kk[i][CW-1:0];
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check("done_seen", int'(done), 1);
        #1;
    endtask

    initial begin
        int saved;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_rst_n", int'(mem_rst_n), 1);
        check("rst_rd", int'(rd), 0);
        check("rst_wr", int'(wr), 0);
        check("rst_pixelw", int'(pixelw), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;

        mode = 0; mul = 1; set_k(16, 0);
        pulse_start();
        wait_done(9000);
        check("id_rewind_t", rew_t, 1);
        check("id_rd_first", rd_first, 2);
        check("id_rd_last", rd_last, 8193);
        check("id_rd_count", rd_n, N);
        check("id_wr_first", wr_first, 5);
        check("id_wr_last", wr_last, 8196);
        check("id_wr_count", wr_n, N);
        check("id_done_t", done_t, 8197);
        check("id_first_pix", first_pix, 185);
        check("id_pix_err", perr, 0);
        @(negedge clk); #1;
        check("id_busy_fall", bfall_t, 8198);
        check("id_busy_low", int'(busy), 0);

        repeat (3) @(posedge clk);
        mode = 1; uval = 90; set_k(1, 1);
        pulse_start();
        repeat (50) @(posedge clk);
        pulse_start();
        wait_done(9000);
        check("box_wr_count", wr_n, N);
        check("box_first_pix", first_pix, 50);
        check("box_pix_err", perr, 0);

        repeat (3) @(posedge clk);
        mode = 1; uval = 255; set_k(31, 0);
        pulse_start();
        wait_done(9000);
        check("sat_hi_wr_count", wr_n, N);
        check("sat_hi_first_pix", first_pix, 255);
        check("sat_hi_pix_err", perr, 0);
        @(posedge clk); #1;
        uval = 200; set_k(-16, 0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(9000);
        check("sat_lo_rd_first", rd_first, 2);
        check("sat_lo_wr_count", wr_n, N);
        check("sat_lo_first_pix", first_pix, 0);
        check("sat_lo_pix_err", perr, 0);

        repeat (3) @(posedge clk);
        mode = 0; mul = 3; set_k(16, 0);
        pulse_start();
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (rd_n < 100 && n < 300);
        check("abort_reached", rd_n, 100);
        rst_n = 1'b0;
        #1;
        check("abort_rd", int'(rd), 0);
        check("abort_wr", int'(wr), 0);
        check("abort_busy", int'(busy), 0);
        saved = rd_n + wr_n;
        repeat (5) @(negedge clk);
        #1;
        check("abort_quiet", rd_n + wr_n, saved);
        @(posedge clk); #1 rst_n = 1'b1;
        pulse_start();
        wait_done(9000);
        check("fresh_wr_count", wr_n, N);
        check("fresh_first_pix", first_pix, 185);
        check("fresh_pix_err", perr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
